// File: rtl/window_scan_pkg.sv
// Shared types and helpers for the window-origin scan sequencer.
//   scan_state_t : sequencer states (IDLE, SCAN, DRAIN, DONE)
//   num_pos()    : number of window origins along one image dimension
//   last_pos()   : coordinate of the last window origin along one dimension
package window_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Origins that fit entirely inside a dimension at the given stride.
  function automatic int unsigned num_pos(input int unsigned dim,
                                          input int unsigned win,
                                          input int unsigned step);
    return (dim - win) / step + 1;
  endfunction

  // Coordinate of the final origin along a dimension.
  function automatic int unsigned last_pos(input int unsigned dim,
                                           input int unsigned win,
                                           input int unsigned step);
    return (num_pos(dim, win, step) - 1) * step;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating-free up/down credit counter tracking in-flight transactions.
// Ports:
//   clk, rst (async active-low)
//   clr   : synchronous clear to zero (has priority)
//   inc   : add one credit in use
//   dec   : release one credit; inc & dec together hold the count
//   count : current number of credits in use
//   full  : count == MAX
//   empty : count == 0
module credit_counter #(
  parameter int unsigned MAX = 4,
  localparam int unsigned W  = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] count_q;

  // Count register; simultaneous inc and dec cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !dec) begin
      count_q <= count_q + W'(1);
    end else if (dec && !inc) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count = count_q;
  assign full  = (count_q == W'(MAX));
  assign empty = (count_q == '0);

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-scans every legal window origin of one frame and issues it on a
// ready/valid stream, bounding in-flight windows and counting detections.
// Ports:
//   clk, rst (async active-low)
//   start                      : begin a frame (honoured only when idle)
//   busy, done                 : frame in progress / one-cycle completion pulse
//   window_pos_valid/ready     : origin stream handshake
//   window_pos_x, window_pos_y : current origin
//   result_valid/ready, result : classifier result stream (1 = face)
//   det_count                  : positive results in the current/last frame
module window_scan_ctrl
  import window_scan_pkg::*;
#(
  parameter int unsigned IMG_WIDTH       = 45,
  parameter int unsigned IMG_HEIGHT      = 45,
  parameter int unsigned WIN_SIZE        = 24,
  parameter int unsigned STEP            = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned W_X   = $clog2(IMG_WIDTH),
  localparam int unsigned W_Y   = $clog2(IMG_HEIGHT),
  localparam int unsigned NX    = num_pos(IMG_WIDTH, WIN_SIZE, STEP),
  localparam int unsigned NY    = num_pos(IMG_HEIGHT, WIN_SIZE, STEP),
  localparam int unsigned W_CNT = $clog2(NX * NY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             window_pos_valid,
  input  logic             window_pos_ready,
  output logic [W_X-1:0]   window_pos_x,
  output logic [W_Y-1:0]   window_pos_y,
  input  logic             result_valid,
  output logic             result_ready,
  input  logic             result,
  output logic [W_CNT-1:0] det_count
);

  localparam int unsigned W_OUT  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned LAST_X = last_pos(IMG_WIDTH, WIN_SIZE, STEP);
  localparam int unsigned LAST_Y = last_pos(IMG_HEIGHT, WIN_SIZE, STEP);

  scan_state_t      state_q, state_d;
  logic [W_X-1:0]   x_q;
  logic [W_Y-1:0]   y_q;
  logic [W_CNT-1:0] det_q;
  logic [W_OUT-1:0] out_count;
  logic             out_full;
  logic             out_empty;
  logic             frame_clr_c;
  logic             pos_hs_c;
  logic             res_hs_c;
  logic             last_x_c;
  logic             last_origin_c;

  // Outputs decoded from registered state and counter only.
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign window_pos_valid = (state_q == SCAN) && !out_full;
  assign result_ready     = ((state_q == SCAN) || (state_q == DRAIN)) && !out_empty;
  assign window_pos_x     = x_q;
  assign window_pos_y     = y_q;
  assign det_count        = det_q;

  assign pos_hs_c      = window_pos_valid && window_pos_ready;
  assign res_hs_c      = result_ready && result_valid;
  assign last_x_c      = (x_q == W_X'(LAST_X));
  assign last_origin_c = last_x_c && (y_q == W_Y'(LAST_Y));

  // In-flight window accounting.
  credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_outstanding (
    .clk   (clk),
    .rst   (rst),
    .clr   (frame_clr_c),
    .inc   (pos_hs_c),
    .dec   (res_hs_c),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    frame_clr_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SCAN;
          frame_clr_c = 1'b1;
        end
      end
      SCAN: begin
        if (pos_hs_c && last_origin_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the counter is (or is about to become) zero.
        if (out_empty || ((out_count == W_OUT'(1)) && res_hs_c)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Origin raster and detection counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      y_q   <= '0;
      det_q <= '0;
    end else if (frame_clr_c) begin
      x_q   <= '0;
      y_q   <= '0;
      det_q <= '0;
    end else begin
      if (pos_hs_c) begin
        if (last_x_c) begin
          x_q <= '0;
          y_q <= y_q + W_Y'(STEP);
        end else begin
          x_q <= x_q + W_X'(STEP);
        end
      end
      if (res_hs_c && result) begin
        det_q <= det_q + W_CNT'(1);
      end
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Randomized self-checking bench for window_scan_ctrl against a frame-level
// reference model (origin list, credit count, detection tally).
module tb_window_scan_ctrl;

  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 6;
  localparam int unsigned WIN   = 4;
  localparam int unsigned STEP  = 2;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned W_X   = $clog2(IMG_W);
  localparam int unsigned W_Y   = $clog2(IMG_H);
  localparam int unsigned W_CNT = $clog2(((IMG_W - WIN) / STEP + 1) *
                                         ((IMG_H - WIN) / STEP + 1) + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             window_pos_valid;
  logic             window_pos_ready;
  logic [W_X-1:0]   window_pos_x;
  logic [W_Y-1:0]   window_pos_y;
  logic             result_valid;
  logic             result_ready;
  logic             result;
  logic [W_CNT-1:0] det_count;

  always #5 clk = ~clk;

  window_scan_ctrl #(
    .IMG_WIDTH       (IMG_W),
    .IMG_HEIGHT      (IMG_H),
    .WIN_SIZE        (WIN),
    .STEP            (STEP),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .window_pos_valid (window_pos_valid),
    .window_pos_ready (window_pos_ready),
    .window_pos_x     (window_pos_x),
    .window_pos_y     (window_pos_y),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result           (result),
    .det_count        (det_count)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: legal origins in raster order plus frame bookkeeping.
  int ox[$];
  int oy[$];
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_idx    = 0;
  int m_out    = 0;
  int m_det    = 0;
  int m_res    = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit exp_valid();
    return m_active && (m_idx < ox.size()) && (m_out < int'(MAXO));
  endfunction

  function automatic bit exp_rready();
    return m_active && (m_out > 0);
  endfunction

  task automatic check_outputs();
    chk("busy",   32'(busy),             32'(m_active || m_done));
    chk("done",   32'(done),             32'(m_done));
    chk("valid",  32'(window_pos_valid), 32'(exp_valid()));
    chk("rready", 32'(result_ready),     32'(exp_rready()));
    chk("det",    32'(det_count),        32'(m_det));
    if (exp_valid()) begin
      chk("pos_x", 32'(window_pos_x), 32'(ox[m_idx]));
      chk("pos_y", 32'(window_pos_y), 32'(oy[m_idx]));
    end
  endtask

  // Advance the model across one clock edge with the inputs now applied.
  task automatic tick();
    bit hp;
    bit hr;
    hp = exp_valid() && window_pos_ready;
    hr = exp_rready() && result_valid;
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_idx = 0;
        m_out = 0;
        m_det = 0;
        m_res = 0;
      end
    end else begin
      if (hp) m_idx++;
      if (hr) begin
        if (result) m_det++;
        m_res++;
      end
      m_out = m_out + (hp ? 1 : 0) - (hr ? 1 : 0);
      if (m_idx == ox.size() && m_out == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check_outputs();
      start            = 1'b0;
      window_pos_ready = 1'($urandom_range(0, 1));
      result_valid     = 1'($urandom_range(0, 1));
      result           = 1'b1;
      tick();
    end
  endtask

  // res_mode: 0 all negative, 1 positives on results #2 and #6, else random.
  task automatic run_frame(input int ready_pct, input int rv_pct, input int hold_c,
                           input bit stall20, input int res_mode, input int abort_at);
    int stall_n;
    bit finished;
    stall_n  = 0;
    finished = 1'b0;
    for (int c = 0; c < 400; c++) begin
      check_outputs();
      if (c > 0 && !m_active && !m_done) begin
        finished = 1'b1;
        break;
      end
      if (abort_at > 0 && m_idx == abort_at) begin
        finished = 1'b1;
        break;
      end
      start = (c == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      if (stall20 && exp_valid() && ox[m_idx] == 2 && oy[m_idx] == 0 && stall_n < 5) begin
        window_pos_ready = 1'b0;
        stall_n++;
      end else begin
        window_pos_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
      result_valid = (c >= hold_c) && (int'($urandom_range(0, 99)) < rv_pct);
      case (res_mode)
        0:       result = 1'b0;
        1:       result = (m_res == 1 || m_res == 5);
        default: result = 1'($urandom_range(0, 1));
      endcase
      tick();
    end
    if (!finished) chk("frame_timeout", 0, 1);
    start            = 1'b0;
    window_pos_ready = 1'b0;
    result_valid     = 1'b0;
    result           = 1'b0;
  endtask

  initial begin
    for (int yy = 0; yy + int'(WIN) <= int'(IMG_H); yy += int'(STEP)) begin
      for (int xx = 0; xx + int'(WIN) <= int'(IMG_W); xx += int'(STEP)) begin
        ox.push_back(xx);
        oy.push_back(yy);
      end
    end

    rst              = 1'b0;
    start            = 1'b0;
    window_pos_ready = 1'b0;
    result_valid     = 1'b0;
    result           = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_x", 32'(window_pos_x), 0);
    chk("rst_y", 32'(window_pos_y), 0);
    check_outputs();
    rst = 1'b1;
    idle_cycles(3);

    // Full-rate scan, prompt results, no detections.
    run_frame(100, 100, 0, 1'b0, 0, 0);
    idle_cycles(2);
    // Results withheld at first: credit limit throttles issue.
    run_frame(100, 100, 10, 1'b0, 2, 0);
    idle_cycles(2);
    // Downstream stall on origin (2,0).
    run_frame(100, 100, 0, 1'b1, 2, 0);
    idle_cycles(2);
    // Positives on 2nd and 6th results; count held through idle traffic.
    run_frame(100, 60, 0, 1'b0, 1, 0);
    chk("det_pattern", 32'(det_count), 2);
    idle_cycles(6);
    // Random back-pressure on both streams.
    for (int f = 0; f < 8; f++) begin
      run_frame(int'($urandom_range(30, 100)), int'($urandom_range(20, 100)),
                int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 2, 0);
      idle_cycles(int'($urandom_range(1, 3)));
    end

    // Asynchronous reset after three issues.
    run_frame(100, 100, 0, 1'b0, 2, 3);
    rst              = 1'b0;
    start            = 1'b0;
    window_pos_ready = 1'b0;
    result_valid     = 1'b0;
    #1;
    chk("arst_busy",   32'(busy),             0);
    chk("arst_done",   32'(done),             0);
    chk("arst_valid",  32'(window_pos_valid), 0);
    chk("arst_rready", 32'(result_ready),     0);
    chk("arst_x",      32'(window_pos_x),     0);
    chk("arst_y",      32'(window_pos_y),     0);
    chk("arst_det",    32'(det_count),        0);
    m_active = 1'b0;
    m_done   = 1'b0;
    m_idx    = 0;
    m_out    = 0;
    m_det    = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);
    run_frame(100, 100, 0, 1'b0, 2, 0);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
